nbit_seq_mult_bcd: RTL and testbench

NBIT_SEQ_MULT_BCD -- requirements
Module: nbit_seq_mult_bcd

---
 rtl/nbit_mult_pkg.sv | 25 ++
 rtl/bcd_to_seg7.sv | 14 +
 rtl/nbit_seq_mult_bcd.sv | 127 ++++++++++++
 tb/tb_nbit_seq_mult_bcd.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/nbit_mult_pkg.sv
// Shared types and constants for the sequential BCD multiplier.
// The seven-segment table is consumed only when SEG7_EN is defined.
package nbit_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    CONV = 2'd2,
    DONE = 2'd3
  } state_e;

  // Decimal digits needed for a 2*w-bit value: ceil(2*w*log10(2)).
  function automatic int bcd_digits(input int w);
    return (2 * w * 301 + 999) / 1000;
  endfunction

  // Active-low segments, bit order gfedcba, indexed by digit 0-9.
  localparam logic [9:0][6:0] SEG7_LUT = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  localparam logic [6:0] SEG7_BLANK = 7'h7f;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-low seven-segment decoder (gfedcba).
module bcd_to_seg7
  import nbit_mult_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG7_BLANK;
    if (bcd < 4'd10) seg = SEG7_LUT[bcd];
  end

endmodule

// File: rtl/nbit_seq_mult_bcd.sv
// Sequential shift-add multiplier followed by double-dabble BCD conversion.
// Optional per-digit seven-segment outputs are enabled by defining SEG7_EN.
module nbit_seq_mult_bcd
  import nbit_mult_pkg::*;
#(
  parameter  int WIDTH  = 4,
  localparam int DIGITS = bcd_digits(WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      q,
  input  logic [WIDTH-1:0]      m,
  output logic                  busy,
  output logic                  done,
`ifdef SEG7_EN
  output logic [7*DIGITS-1:0]   hex,
`endif
  output logic [2*WIDTH-1:0]    p,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int CW = $clog2(2 * WIDTH) + 1;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [2*WIDTH-1:0]    acc_q, acc_d, p_q, p_d, acc_rot;
  logic [WIDTH-1:0]      m_q, m_d;
  logic [4*DIGITS-1:0]   dd_q, dd_d, bcd_q, bcd_d, dd_adj, dd_shift;
  logic [WIDTH:0]        sum;
  logic                  mult_last, conv_last;

  assign mult_last = (cnt_q == CW'(WIDTH - 1));
  assign conv_last = (cnt_q == CW'(2 * WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      m_q     <= '0;
      dd_q    <= '0;
      p_q     <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      m_q     <= m_d;
      dd_q    <= dd_d;
      p_q     <= p_d;
      bcd_q   <= bcd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = MULT;
      MULT:    if (mult_last) state_d = CONV;
      CONV:    if (conv_last) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  // acc holds {upper, lower}; lower starts as q and is consumed LSB first.
  // During CONV acc is rotated so it reads the product MSB first and returns
  // to the original product after exactly 2*WIDTH steps.
  always_comb begin
    sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + ({1'b0, m_q} & {(WIDTH+1){acc_q[0]}});
    acc_rot  = {acc_q[2*WIDTH-2:0], acc_q[2*WIDTH-1]};
    dd_adj   = dd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (dd_q[4*i +: 4] >= 4'd5) dd_adj[4*i +: 4] = dd_q[4*i +: 4] + 4'd3;
    end
    dd_shift = {dd_adj[4*DIGITS-2:0], acc_q[2*WIDTH-1]};

    cnt_d = cnt_q;
    acc_d = acc_q;
    m_d   = m_q;
    dd_d  = dd_q;
    p_d   = p_q;
    bcd_d = bcd_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d = {{WIDTH{1'b0}}, q};
          m_d   = m;
          cnt_d = '0;
          dd_d  = '0;
        end
      end
      MULT: begin
        acc_d = {sum, acc_q[WIDTH-1:1]};
        cnt_d = mult_last ? '0 : cnt_q + 1'b1;
      end
      CONV: begin
        acc_d = acc_rot;
        dd_d  = dd_shift;
        cnt_d = conv_last ? '0 : cnt_q + 1'b1;
        if (conv_last) begin
          p_d   = acc_rot;
          bcd_d = dd_shift;
        end
      end
      default: ;
    endcase
  end

  assign p   = p_q;
  assign bcd = bcd_q;

`ifdef SEG7_EN
  for (genvar g = 0; g < DIGITS; g++) begin : g_seg
    bcd_to_seg7 u_seg (
      .bcd (bcd_q[4*g +: 4]),
      .seg (hex[7*g +: 7])
    );
  end
`endif

endmodule

// File: tb/tb_nbit_seq_mult_bcd.sv
// Scoreboard bench for nbit_seq_mult_bcd at WIDTH=4 and WIDTH=8.
// Hex outputs are checked only when SEG7_EN is defined.
module tb_nbit_seq_mult_bcd;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start4, start8;
  logic [3:0]  q4, m4;
  logic [7:0]  q8, m8;
  logic        busy4, done4, busy8, done8;
  logic [7:0]  p4;
  logic [11:0] bcd4;
  logic [15:0] p8;
  logic [19:0] bcd8;
`ifdef SEG7_EN
  logic [20:0] hex4;
  logic [34:0] hex8;
`endif

  nbit_seq_mult_bcd #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .q(q4), .m(m4),
    .busy(busy4), .done(done4),
`ifdef SEG7_EN
    .hex(hex4),
`endif
    .p(p4), .bcd(bcd4)
  );

  nbit_seq_mult_bcd #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .q(q8), .m(m8),
    .busy(busy8), .done(done8),
`ifdef SEG7_EN
    .hex(hex8),
`endif
    .p(p8), .bcd(bcd8)
  );

  typedef struct {
    logic [31:0] p;
    logic [31:0] bcd;
    int          cyc;
  } exp_t;

  exp_t sb4[$];
  exp_t sb8[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] to_bcd(input int unsigned v);
    logic [31:0] r;
    int unsigned t;
    r = '0;
    t = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_ref(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;  4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;  4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;  4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;  4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;  4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Latency: operands driven in cycle N, done observed N+3*WIDTH+1.
  always @(posedge clk) begin : mon4
    exp_t e;
    #1;
    if (done4 === 1'b1) begin
      if (sb4.size() == 0) chk("done4_spurious", 64'(done4), 64'd0);
      else begin
        e = sb4.pop_front();
        chk("p4", 64'(p4), 64'(e.p));
        chk("bcd4", 64'(bcd4), 64'(e.bcd));
        chk("lat4", 64'(cyc), 64'(e.cyc + 13));
      end
    end
  end

  always @(posedge clk) begin : mon8
    exp_t e;
    #1;
    if (done8 === 1'b1) begin
      if (sb8.size() == 0) chk("done8_spurious", 64'(done8), 64'd0);
      else begin
        e = sb8.pop_front();
        chk("p8", 64'(p8), 64'(e.p));
        chk("bcd8", 64'(bcd8), 64'(e.bcd));
        chk("lat8", 64'(cyc), 64'(e.cyc + 25));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push4(input int a, input int b);
    exp_t e;
    e.p = 32'(a * b);
    e.bcd = to_bcd(a * b);
    e.cyc = cyc;
    sb4.push_back(e);
  endtask

  task automatic op4(input int a, input int b);
    q4 = 4'(a); m4 = 4'(b); start4 = 1'b1;
    push4(a, b);
    tick(1);
    start4 = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((sb4.size() != 0 || sb8.size() != 0) && n < budget) begin
      tick(1);
      n++;
    end
    chk("drain_timeout", 64'(sb4.size() + sb8.size()), 64'd0);
    tick(3);
  endtask

  initial begin
    exp_t e;
    rst = 1'b1; start4 = 1'b0; start8 = 1'b0;
    q4 = '0; m4 = '0; q8 = '0; m8 = '0;
    tick(2);
    chk("rst_busy", 64'(busy4), 64'd0);
    chk("rst_done", 64'(done4), 64'd0);
    chk("rst_p", 64'(p4), 64'd0);
    chk("rst_bcd", 64'(bcd4), 64'd0);
    rst = 1'b0;
    tick(1);

    op4(15, 15);
    chk("busy_after_accept", 64'(busy4), 64'd1);
    drain(40);
    chk("p225_hold", 64'(p4), 64'd225);
`ifdef SEG7_EN
    chk("hex4_d0", 64'(hex4[6:0]), 64'(seg_ref(bcd4[3:0])));
    chk("hex4_d2", 64'(hex4[20:14]), 64'(seg_ref(4'd2)));
`endif

    op4(7, 6);
    tick(2);
    chk("p_held_during_op", 64'(p4), 64'd225);
    drain(40);
    op4(0, 9);
    drain(40);

    // Starts mid-operation must be ignored.
    op4(3, 5);
    tick(1);
    q4 = 4'd9; m4 = 4'd9; start4 = 1'b1;
    tick(1);
    start4 = 1'b0;
    tick(4);
    start4 = 1'b1;
    tick(1);
    start4 = 1'b0;
    drain(40);
    chk("ignored_start_idle", 64'(busy4), 64'd0);

    // Reset mid-operation, with start also asserted on the reset edge.
    op4(13, 11);
    tick(5);
    rst = 1'b1; start4 = 1'b1; q4 = 4'd2; m4 = 4'd2;
    void'(sb4.pop_back());
    tick(1);
    chk("midrst_busy", 64'(busy4), 64'd0);
    chk("midrst_p", 64'(p4), 64'd0);
    chk("midrst_bcd", 64'(bcd4), 64'd0);
    rst = 1'b0; start4 = 1'b0;
    tick(16);
    chk("midrst_no_done", 64'(sb4.size()), 64'd0);
    op4(13, 11);
    drain(40);

    q8 = 8'd255; m8 = 8'd255; start8 = 1'b1;
    e.p = 32'd65025; e.bcd = to_bcd(65025); e.cyc = cyc;
    sb8.push_back(e);
    tick(1);
    start8 = 1'b0;
    drain(60);
    chk("bcd8_hex", 64'(bcd8), 64'h65025);

    // Exhaustive sweep with start held high: one accept every 14 cycles.
    start4 = 1'b1;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        q4 = 4'(a); m4 = 4'(b);
        push4(a, b);
        tick(14);
      end
    end
    start4 = 1'b0;
    drain(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
